demodulator: RTL and testbench

Receive-side counterpart of the OPPM `Modulator`. It takes the single-bit `pulse` stream, slices it into symbol frames of `L*2**N` clocks, and recovers one N-bit symbol per frame from the slot position of the pulse's rising edge. Frame alignment comes from an external `start` strobe; in the link this strobe is issued by the `Decoder` preamble logic. Each frame produces one registered `valid` strobe carrying the symbol or an error flag.

---
 rtl/demodulator.sv | 135 +++++++++++++
 tb/tb_demodulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demodulator.sv
// demodulator: OPPM receive-side symbol recovery.
// Slices the pulse stream into frames of L*2**N clocks aligned by the start
// strobe and recovers one N-bit symbol per frame from the slot holding the
// pulse's rising edge. One registered valid strobe is issued per complete frame.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   pulse   in   received pulse, synchronous to clk
//   start   in   one-cycle alignment strobe; next cycle is frame offset 0
//   stop    in   return to IDLE (wins over start)
//   data    out  recovered symbol, held until the next valid
//   valid   out  one-cycle strobe per completed frame
//   err     out  frame had zero edges or more than one
//   active  out  high while in ACTIVE
module demodulator #(
   parameter int unsigned N = 2,
   parameter int unsigned L = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pulse,
   input  logic         start,
   input  logic         stop,
   output logic [N-1:0] data,
   output logic         valid,
   output logic         err,
   output logic         active
);

   localparam int unsigned     SUB_W     = (L > 1) ? $clog2(L) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(L - 1);
   localparam logic [N-1:0]     SLOT_LAST = '1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t           state, state_nx;
   logic [SUB_W-1:0] sub;
   logic [N-1:0]     slot;
   logic             pulse_q;
   logic [1:0]       edge_cnt;
   logic [N-1:0]     cap;

   logic             accept_start;
   logic             is_active;
   logic             rise;
   logic             frame_end;
   logic             emit;
   logic [1:0]       cnt_final;
   logic [N-1:0]     cap_final;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: stop has priority over start
   always_comb begin
      state_nx = state;
      if (stop)       state_nx = IDLE;
      else if (start) state_nx = ACTIVE;
   end

   // Output logic
   always_comb begin
      active = (state == ACTIVE);
   end

   // Frame bookkeeping. The last cycle of a frame may itself carry an edge,
   // so the emitted count/capture fold in the current cycle's edge.
   always_comb begin
      accept_start = start & ~stop;
      is_active    = (state == ACTIVE);
      rise         = is_active & pulse & ~pulse_q;
      frame_end    = is_active && (sub == SUB_LAST) && (slot == SLOT_LAST);
      emit         = frame_end & ~start & ~stop;
      cnt_final    = edge_cnt;
      cap_final    = cap;
      if (rise && edge_cnt != 2'd2) cnt_final = edge_cnt + 2'd1;
      if (rise && edge_cnt == 2'd0) cap_final = slot;
   end

   // Edge detect register runs in every state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pulse_q <= 1'b0;
      else        pulse_q <= pulse;
   end

   // Slot/sub counters; cleared on alignment, stop, or while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub  <= '0;
         slot <= '0;
      end else if (accept_start || stop || !is_active) begin
         sub  <= '0;
         slot <= '0;
      end else if (sub == SUB_LAST) begin
         sub  <= '0;
         slot <= slot + 1'b1;
      end else begin
         sub  <= sub + 1'b1;
      end
   end

   // Per-frame edge count (saturating at 2) and first-edge slot capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         cap      <= '0;
      end else if (accept_start || stop || frame_end) begin
         edge_cnt <= '0;
         cap      <= '0;
      end else begin
         edge_cnt <= cnt_final;
         cap      <= cap_final;
      end
   end

   // Registered result; data/err hold between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         err   <= 1'b0;
         data  <= '0;
      end else begin
         valid <= emit;
         if (emit) begin
            err  <= (cnt_final != 2'd1);
            data <= (cnt_final == 2'd1) ? cap_final : '0;
         end
      end
   end

endmodule

// File: tb/tb_demodulator.sv
// tb_demodulator: directed, table-driven bench for demodulator (N=2, L=4).
// Each table record is one 16-cycle frame of pulse levels (bit i = offset i)
// plus the expected symbol/error flag for that frame.
module tb_demodulator;

   localparam int unsigned N  = 2;
   localparam int unsigned L  = 4;
   localparam int unsigned FL = L * (2 ** N);

   typedef struct {
      logic [15:0] pat;
      logic [1:0]  d;
      logic        e;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pulse;
   logic       start;
   logic       stop;
   logic [1:0] data;
   logic       valid;
   logic       err;
   logic       active;

   int passed = 0;
   int total  = 0;

   frame_t vec[$];

   demodulator #(.N(N), .L(L)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pulse  (pulse),
      .start  (start),
      .stop   (stop),
      .data   (data),
      .valid  (valid),
      .err    (err),
      .active (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   function automatic frame_t mk(input logic [15:0] pat, input logic [1:0] d, input logic e);
      frame_t f;
      f.pat = pat;
      f.d   = d;
      f.e   = e;
      return f;
   endfunction

   // Issue start, then play every frame of vec back-to-back. Outputs are
   // checked at each negedge; frame f's result is due at offset 0 of f+1.
   // Returns at the negedge of offset 0 following the last frame.
   task automatic run_frames();
      int n;
      n = vec.size();
      @(negedge clk);
      start = 1'b1;
      pulse = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= n * FL; c++) begin
         int f;
         int o;
         f = c / FL;
         o = c % FL;
         pulse = (f < n) ? vec[f].pat[o] : 1'b0;
         chk("active_run", {31'd0, active}, 32'd1);
         if (o == 0 && f > 0) begin
            chk("valid_frame", {31'd0, valid}, 32'd1);
            chk("err_frame", {31'd0, err}, {31'd0, vec[f-1].e});
            chk("data_frame", {30'd0, data}, {30'd0, vec[f-1].d});
         end else begin
            chk("valid_quiet", {31'd0, valid}, 32'd0);
         end
         if (c < n * FL) @(negedge clk);
      end
   endtask

   task automatic do_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("active_after_stop", {31'd0, active}, 32'd0);
   endtask

   task automatic quiet(input int cycles, input string name);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk(name, {31'd0, valid}, 32'd0);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      pulse = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      #2;
      chk("rst_data", {30'd0, data}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single symbol, back-to-back, error frames, overlap across frames
      vec.delete();
      vec.push_back(mk(16'h0100, 2'd2, 1'b0)); // offset 8
      vec.push_back(mk(16'h0001, 2'd0, 1'b0)); // offset 0
      vec.push_back(mk(16'h0020, 2'd1, 1'b0)); // offset 5
      vec.push_back(mk(16'h8000, 2'd3, 1'b0)); // offset 15
      vec.push_back(mk(16'h0000, 2'd0, 1'b1)); // no edge
      vec.push_back(mk(16'h0404, 2'd0, 1'b1)); // offsets 2 and 10
      vec.push_back(mk(16'hC000, 2'd3, 1'b0)); // high 14..15
      vec.push_back(mk(16'h1003, 2'd3, 1'b0)); // still high 0..1, edge at 12
      run_frames();
      do_stop();

      // Reset mid-frame with pulse high: everything clears at once
      chk("data_before_reset", {30'd0, data}, 32'd3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulse = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_data", {30'd0, data}, 32'd0);
      chk("mid_rst_valid", {31'd0, valid}, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      chk("mid_rst_active", {31'd0, active}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         pulse = (i % 4 == 1);
         @(negedge clk);
         chk("post_rst_active", {31'd0, active}, 32'd0);
         chk("post_rst_valid", {31'd0, valid}, 32'd0);
      end
      pulse = 1'b0;

      // start and stop together: stays IDLE
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk("start_stop_active", {31'd0, active}, 32'd0);
      quiet(20, "start_stop_valid");

      // Loopback: modulator model places a 1-cycle pulse at offset d*L
      vec.delete();
      for (int i = 0; i < 10; i++) begin
         logic [1:0]  d;
         logic [15:0] p;
         d = 2'($urandom_range(0, 3));
         p = 16'h0001 << (d * L);
         vec.push_back(mk(p, d, 1'b0));
      end
      run_frames();
      do_stop();

      // Abort: stop at offset 9 discards the partial frame
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int o = 0; o < 9; o++) begin
         pulse = (o == 4);
         @(negedge clk);
      end
      pulse = 1'b0;
      do_stop();
      quiet(24, "abort_valid");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
